// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : move_scheduler
// Brief    : Move-segment FIFO feeding a DDA step generator (step/dir output).
// Revision : 1.0  initial release
// ============================================================================
module move_scheduler #(
    parameter int BUFFER_DEPTH = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int TICK_WIDTH   = 32
) (
    input  logic                              CLK,
    input  logic                              resetn,
    input  logic                              move_valid,
    output logic                              move_ready,
    input  logic                              move_dir,
    input  logic [ACC_WIDTH-1:0]              move_increment,
    input  logic [ACC_WIDTH-1:0]              move_incrinc,
    input  logic [TICK_WIDTH-1:0]             move_ticks,
    input  logic                              tick,
    input  logic                              halt,
    output logic                              step,
    output logic                              dir,
    output logic                              move_done,
    output logic                              buffer_dtr,
    output logic                              busy,
    output logic [$clog2(BUFFER_DEPTH):0]     moves_queued
);

    localparam int PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + 2 * ACC_WIDTH + TICK_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ENTRY_W-1:0]     r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_inc;
    logic [ACC_WIDTH-1:0]   r_incinc;
    logic [TICK_WIDTH-1:0]  r_ticks_rem;
    logic                   r_step;
    logic                   r_dir;
    logic                   r_done;

    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic [ENTRY_W-1:0]     w_head;
    logic                   w_head_dir;
    logic [ACC_WIDTH-1:0]   w_head_inc;
    logic [ACC_WIDTH-1:0]   w_head_incinc;
    logic [TICK_WIDTH-1:0]  w_head_ticks;
    logic [ACC_WIDTH:0]     w_sum;
    logic [ACC_WIDTH+1:0]   w_inc_ext;
    logic [ACC_WIDTH-1:0]   w_inc_sat;
    logic                   w_tick_run;
    logic                   w_last_tick;
    logic                   w_zero_load;

    assign w_full     = (r_count == CNT_W'(BUFFER_DEPTH));
    assign move_ready = !w_full && !halt;
    assign w_push     = move_valid && move_ready;
    assign w_pop      = (r_state == S_LOAD) && !halt;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_dir    = w_head[ENTRY_W-1];
    assign w_head_inc    = w_head[ENTRY_W-2 -: ACC_WIDTH];
    assign w_head_incinc = w_head[ACC_WIDTH+TICK_WIDTH-1 -: ACC_WIDTH];
    assign w_head_ticks  = w_head[TICK_WIDTH-1:0];

    // Increment update is evaluated two bits wider so the signed step can be
    // clamped at both ends instead of wrapping.
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_inc_ext = {2'b00, r_inc} + {{2{r_incinc[ACC_WIDTH-1]}}, r_incinc};
    assign w_inc_sat = w_inc_ext[ACC_WIDTH+1] ? '0 :
                       (w_inc_ext[ACC_WIDTH] ? '1 : w_inc_ext[ACC_WIDTH-1:0]);

    assign w_tick_run  = (r_state == S_RUN) && tick && !halt;
    assign w_last_tick = w_tick_run && (r_ticks_rem == TICK_WIDTH'(1));
    assign w_zero_load = w_pop && (w_head_ticks == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_next = S_LOAD;
            S_LOAD: begin
                if (w_head_ticks == '0)
                    w_state_next = (r_count > CNT_W'(1)) ? S_LOAD : S_IDLE;
                else
                    w_state_next = S_RUN;
            end
            S_RUN:  if (w_last_tick)
                        w_state_next = (r_count != '0) ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (halt) w_state_next = S_IDLE;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {move_dir, move_increment, move_incrinc, move_ticks};
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (halt) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_acc       <= '0;
            r_inc       <= '0;
            r_incinc    <= '0;
            r_ticks_rem <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
        end else if (halt) begin
            r_acc       <= '0;
            r_ticks_rem <= '0;
            r_step      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_done <= w_last_tick || w_zero_load;
            if (w_pop) begin
                r_dir       <= w_head_dir;
                r_inc       <= w_head_inc;
                r_incinc    <= w_head_incinc;
                r_ticks_rem <= w_head_ticks;
            end
            if (w_tick_run) begin
                r_step      <= w_sum[ACC_WIDTH];
                r_acc       <= w_sum[ACC_WIDTH-1:0];
                r_inc       <= w_inc_sat;
                r_ticks_rem <= r_ticks_rem - TICK_WIDTH'(1);
            end
            // Residue survives back-to-back segments but not a return to idle.
            if ((w_state_next == S_IDLE) && (r_state != S_IDLE))
                r_acc <= '0;
        end
    end

    assign step         = r_step;
    assign dir          = r_dir;
    assign move_done    = r_done;
    assign buffer_dtr   = !w_full;
    assign busy         = (r_state != S_IDLE);
    assign moves_queued = r_count;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_scheduler
// Brief    : Self-checking bench for move_scheduler against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_move_scheduler;

    localparam int     DEPTH = 4;
    localparam int     AW    = 32;
    localparam int     TW    = 32;
    localparam longint AMAX  = 64'h0000_0000_FFFF_FFFF;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          move_valid = 1'b0;
    logic          move_ready;
    logic          move_dir = 1'b0;
    logic [AW-1:0] move_increment = '0;
    logic [AW-1:0] move_incrinc = '0;
    logic [TW-1:0] move_ticks = '0;
    logic          tick = 1'b0;
    logic          halt = 1'b0;
    logic          step;
    logic          dir;
    logic          move_done;
    logic          buffer_dtr;
    logic          busy;
    logic [2:0]    moves_queued;

    always #5 CLK = ~CLK;

    move_scheduler #(
        .BUFFER_DEPTH (DEPTH),
        .ACC_WIDTH    (AW),
        .TICK_WIDTH   (TW)
    ) u_dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .move_dir       (move_dir),
        .move_increment (move_increment),
        .move_incrinc   (move_incrinc),
        .move_ticks     (move_ticks),
        .tick           (tick),
        .halt           (halt),
        .step           (step),
        .dir            (dir),
        .move_done      (move_done),
        .buffer_dtr     (buffer_dtr),
        .busy           (busy),
        .moves_queued   (moves_queued)
    );

    typedef struct {
        bit     d;
        longint inc;
        longint ii;
        longint t;
    } seg_t;

    // Reference model: pending segments plus the segment currently executing.
    seg_t   m_q[$];
    int     m_phase;            // 0 waiting, 1 fetching, 2 executing
    longint m_acc, m_inc, m_ii, m_rem;
    bit     m_dir, m_step, m_done;

    int n_checks = 0;
    int n_pass   = 0;
    int obs_steps, obs_done;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_acc = 0; m_inc = 0; m_ii = 0; m_rem = 0;
        m_dir = 0; m_step = 0; m_done = 0;
    endtask

    task automatic check_outputs();
        check_eq("step",         step,         m_step);
        check_eq("dir",          dir,          m_dir);
        check_eq("move_done",    move_done,    m_done);
        check_eq("busy",         busy,         m_phase != 0);
        check_eq("moves_queued", moves_queued, m_q.size());
        check_eq("buffer_dtr",   buffer_dtr,   m_q.size() < DEPTH);
        check_eq("move_ready",   move_ready,   (m_q.size() < DEPTH) && !halt);
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_edge();
        int     cnt;
        bit     push;
        seg_t   s, nseg;
        longint sum, ni;
        cnt  = m_q.size();
        push = move_valid && (cnt < DEPTH) && !halt;
        nseg.d = move_dir; nseg.inc = move_increment;
        nseg.ii = longint'($signed(move_incrinc)); nseg.t = move_ticks;
        if (halt) begin
            m_q.delete();
            m_phase = 0; m_acc = 0; m_rem = 0; m_step = 0; m_done = 0;
            return;
        end
        m_step = 0; m_done = 0;
        case (m_phase)
            0: if (cnt > 0) m_phase = 1;
            1: begin
                s = m_q.pop_front();
                m_dir = s.d; m_inc = s.inc; m_ii = s.ii; m_rem = s.t;
                if (s.t == 0) begin
                    m_done  = 1;
                    m_phase = (cnt > 1) ? 1 : 0;
                end else m_phase = 2;
            end
            default: if (tick) begin
                sum    = m_acc + m_inc;
                m_step = (sum > AMAX);
                m_acc  = sum & AMAX;
                ni     = m_inc + m_ii;
                m_inc  = (ni < 0) ? 0 : ((ni > AMAX) ? AMAX : ni);
                m_rem  = m_rem - 1;
                if (m_rem == 0) begin
                    m_done  = 1;
                    m_phase = (cnt > 0) ? 1 : 0;
                end
            end
        endcase
        if (m_phase == 0) m_acc = 0;
        if (push) m_q.push_back(nseg);
    endtask

    task automatic cyc();
        #1;
        check_outputs();
        obs_steps += int'(step);
        obs_done  += int'(move_done);
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_seg(input bit d, input longint inc, input longint ii, input longint t);
        move_valid     = 1'b1;
        move_dir       = d;
        move_increment = AW'(inc);
        move_incrinc   = AW'(ii);
        move_ticks     = TW'(t);
    endtask

    task automatic push_seg(input bit d, input longint inc, input longint ii, input longint t);
        set_seg(d, inc, ii, t);
        cyc();
        move_valid = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            tick = ((i % period) == period - 1);
            cyc();
        end
        tick = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        resetn = 1'b1;

        // Constant-rate segment, half-rate increment
        obs_steps = 0; obs_done = 0;
        push_seg(1'b1, 64'h8000_0000, 0, 8);
        run_ticks(40, 4);
        check_eq("t1_steps", obs_steps, 4);
        check_eq("t1_done",  obs_done,  1);

        // Fill the FIFO and hold off a fifth push
        for (int i = 0; i < 4; i++) push_seg(1'b0, 64'hFFFF_FFFF, 0, 2);
        check_eq("fill_queued", moves_queued, 3);
        set_seg(1'b1, 64'h1234, 0, 2);
        for (int i = 0; i < 4; i++) cyc();
        move_valid = 1'b0;
        run_ticks(40, 1);

        // Acceleration with saturating increment
        obs_steps = 0; obs_done = 0;
        push_seg(1'b1, 0, 64'h1000_0000, 20);
        run_ticks(50, 2);
        check_eq("accel_ge8", obs_steps >= 8, 1);
        check_eq("accel_done", obs_done, 1);

        // Zero-tick segment sandwiched between two normal ones
        obs_steps = 0; obs_done = 0;
        push_seg(1'b0, 64'h8000_0000, 0, 3);
        push_seg(1'b1, 64'h8000_0000, 0, 0);
        push_seg(1'b0, 64'h8000_0000, 0, 3);
        run_ticks(20, 1);
        check_eq("zero_steps", obs_steps, 3);
        check_eq("zero_done",  obs_done,  3);

        // Halt mid-run with two segments queued, pushes offered throughout
        obs_done = 0;
        push_seg(1'b1, 64'h4000_0000, 0, 50);
        push_seg(1'b0, 64'h4000_0000, 0, 50);
        push_seg(1'b1, 64'h4000_0000, 0, 50);
        run_ticks(6, 1);
        halt = 1'b1;
        set_seg(1'b0, 64'h8000_0000, 0, 4);
        tick = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        halt = 1'b0; move_valid = 1'b0; tick = 1'b0;
        cyc();
        check_eq("halt_done", obs_done, 0);
        run_ticks(10, 1);

        // Asynchronous reset between edges mid-run
        push_seg(1'b1, 64'h8000_0000, 0, 50);
        push_seg(1'b0, 64'h8000_0000, 0, 50);
        run_ticks(6, 1);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_step", step, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_queued", moves_queued, 0);
        check_eq("arst_dir", dir, 0);
        check_eq("arst_dtr", buffer_dtr, 1);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        obs_steps = 0; obs_done = 0;
        push_seg(1'b0, 64'hC000_0000, 0, 4);
        run_ticks(15, 1);
        check_eq("post_rst_steps", obs_steps, 3);
        check_eq("post_rst_done",  obs_done,  1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            move_valid     = ($urandom_range(0, 2) != 0);
            move_dir       = 1'($urandom_range(0, 1));
            move_increment = $urandom;
            case ($urandom_range(0, 3))
                0:       move_incrinc = '0;
                1:       move_incrinc = AW'($urandom_range(0, 255)) << 20;
                2:       move_incrinc = -(AW'($urandom_range(0, 255)) << 20);
                default: move_incrinc = $urandom;
            endcase
            move_ticks = TW'($urandom_range(0, 6));
            tick       = 1'($urandom_range(0, 1));
            halt       = ($urandom_range(0, 59) == 0);
            cyc();
        end
        move_valid = 1'b0; halt = 1'b0; tick = 1'b1;
        for (int i = 0; i < 40; i++) cyc();
        tick = 1'b0;
        cyc();
        check_eq("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/move_scheduler.md
# move_scheduler

Motion-segment scheduler for the rapcore step/dir path. Queues move segments written by the SPI command decoder into a small FIFO. Sequences them one at a time through an integrated DDA: velocity accumulation and step-pulse generation on each tick strobe. Drives the step/dir pins plus the BUFFER_DTR and MOVE_DONE status pins, and flushes everything on HALT.

## Interface
Parameters:
- BUFFER_DEPTH, 4 — FIFO entries; power of two, ≥2.
- ACC_WIDTH, 32 — width of the increment, increment-increment and phase accumulator.
- TICK_WIDTH, 32 — width of the per-move tick count.

Ports:
- CLK  in  1  — system clock.
- resetn  in  1  — asynchronous, active-low reset.
- move_valid  in  1  — segment offered on the move_* inputs.
- move_ready  out  1  — segment accepted on CLK edge when move_valid & move_ready.
- move_dir  in  1  — direction for the segment.
- move_increment  in  ACC_WIDTH  — initial per-tick phase increment, unsigned.
- move_incrinc  in  ACC_WIDTH  — per-tick change of the increment, two's complement.
- move_ticks  in  TICK_WIDTH  — number of ticks in the segment.
- tick  in  1  — single-cycle DDA tick strobe.
- halt  in  1  — level; abort and flush.
- step  out  1  — step pulse, one CLK wide.
- dir  out  1  — direction output.
- move_done  out  1  — one-cycle pulse on normal segment completion.
- buffer_dtr  out  1  — FIFO has a free slot.
- busy  out  1  — state ≠ IDLE.
- moves_queued  out  $clog2(BUFFER_DEPTH)+1  — FIFO occupancy.

## Operation
- FIFO entry: {dir, increment, incrinc, ticks}. Push when move_valid & move_ready. Pop only in the LOAD state.
- move_ready = !full & !halt. It is computed from the registered count; there is no same-cycle pass-through when full.
- buffer_dtr = !full, independent of halt.
- FSM states:
  - IDLE → LOAD when count > 0 and !halt.
  - LOAD: pop the entry; latch dir, inc, incinc, ticks_rem.
    - If ticks = 0, pulse move_done and go to LOAD if count after pop > 0, else IDLE.
    - Otherwise go to RUN.
  - RUN: on each tick:
    - {carry, acc} = acc + inc, computed at ACC_WIDTH+1 bits; step ← carry.
    - inc ← inc + incinc, saturating at 0 and at 2^ACC_WIDTH−1 (no wrap).
    - ticks_rem ← ticks_rem − 1. When it reaches 0, pulse move_done and go to LOAD if count > 0, else IDLE.
- The accumulator carries its residue across back-to-back segments. It is cleared on entering IDLE and on halt.
- Ticks arriving in IDLE or LOAD are ignored and not queued.
- Halt (highest priority, every state):
  - Clear the FIFO, acc and ticks_rem; go to IDLE.
  - step = 0. No move_done for the aborted segment.
  - Pushes are refused while halt is high.
  - dir holds its last value.
- Simultaneous push and pop in LOAD: both occur; count unchanged.

## Timing
- Reset values: step 0, dir 0, move_done 0, busy 0, moves_queued 0, buffer_dtr 1, move_ready 1 (if halt is low), FSM IDLE, acc 0.
- Push at edge N → moves_queued updated after edge N.
- From IDLE: the FSM enters LOAD at edge N+1 and RUN at edge N+2.
- dir updates at the edge leaving LOAD. It is therefore stable ≥1 CLK before any step of that segment.
- step/move_done are registered. A tick sampled at edge K yields step/move_done high during cycle K→K+1, for exactly one cycle.
- move_done for the last tick coincides with that tick's step, if any.
- Back-to-back segments: one LOAD cycle between the final tick of segment i and the first accepted tick of segment i+1.
- Asynchronous reset mid-move: all outputs go to reset values immediately. The queued segments are lost.

## Test plan
- Reset, push one segment {dir=1, inc=0x8000_0000, incinc=0, ticks=8}, tick every 4 CLK → dir=1 before the first step; 4 steps on ticks 2,4,6,8; one move_done with the 8th-tick step; busy drops; FSM back to IDLE.
- Fill the FIFO with 4 segments (ticks=2, inc=0xFFFF_FFFF) with no ticks → after 4 pushes, moves_queued=3 (one segment popped into LOAD/RUN); push a 5th while count=4 → held off by move_ready=0; buffer_dtr low only while count=4.
- Acceleration: inc=0, incinc=0x1000_0000, ticks=20 → step spacing shrinks monotonically; inc saturates and does not wrap; 8 or more steps total (golden model check).
- Segment with ticks=0 between two normal segments → no step; move_done pulses in the LOAD cycle; the next segment loads the following cycle.
- Halt asserted mid-RUN with 2 queued → next cycle: FIFO empty, busy 0, no further steps, no move_done; pushes refused until halt deasserts.
- resetn pulsed low mid-RUN (asynchronous, between edges) → step/busy/moves_queued go to 0 immediately; after release, a new push runs normally.
